data_mem_resp: RTL and testbench
================================

# data_mem_resp

Responder end of the CPU data-memory handshake: a DEPTH×DW register-based data store that services one read or one write request at a time. It sits beside the `cpu` core's pipeline control on the `in_data_mem` / `write_data` request lines. It answers each request with a one-cycle `out_data_mem` acknowledge and, for reads, the addressed word on `data`.

## Interface
- `DW`, 16: data word width.
- `AW`, 4: address width.
- `DEPTH`, 16: number of implemented words; must satisfy DEPTH ≤ 2^AW.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_data_mem` in 1: read request, level; held high by the initiator until acknowledged.
- `adr_data` in AW: read address, sampled with the read request.
- `write_data` in 1: write request, level; held high until acknowledged.
- `adr_data_write` in AW: write address, sampled with the write request.
- `data_write` in DW: write data, sampled with the write request.
- `data` out DW: read data; updated only when a read completes, holds otherwise.
- `out_data_mem` out 1: acknowledge pulse for a completed read or write.

## Operation
- States: IDLE, RD, WAIT (macro only), WR, DONE.
- IDLE:
  - `write_data`=1: latch `adr_data_write`/`data_write` → WR. Write has priority over a simultaneous read; the read stays pending and is served on the next IDLE.
  - else `in_data_mem`=1: latch `adr_data` → RD.
  - else stay in IDLE.
- RD: `data` ← mem[addr], `out_data_mem` ← 1 → DONE (→ WAIT first when the macro is defined).
- WR: mem[addr] ← latched data, `out_data_mem` ← 1 → DONE.
- DONE: `out_data_mem` ← 0 → IDLE; requests are ignored in this state, giving a one-cycle turnaround.
- Request still high at the next IDLE edge: treated as a new request. The initiator must drop the request on the cycle it sees the ack.
- Address ≥ DEPTH: read returns all-zero `data` with a normal ack; write is dropped with a normal ack; no stored word is altered.
- Write followed by read of the same address: the read returns the new value; there is no stale window.
- Request deasserted while in RD/WR: the transaction still completes and acks; no abort.

## Timing
- Reset (`rst_n`=0, any state): state=IDLE, `out_data_mem`=0, `data`=0, all memory words=0; takes effect immediately, mid-transaction included; the pending transaction is lost.
- Read latency: request sampled at edge N → `data` valid and `out_data_mem`=1 after edge N+1 → `out_data_mem`=0 after edge N+2.
- Write latency: identical; memory is updated at edge N+1.
- Throughput: one transaction per 3 cycles (4 with the macro).
- `out_data_mem` is high for exactly one cycle per transaction and is never high in two consecutive cycles.
- `data` changes only at a read-completion edge.

## Configuration
- `DATA_MEM_WAIT_EN` defined:
  - RD → WAIT → DONE, with `data`/`out_data_mem` set on the WAIT edge.
  - Read latency becomes 3 edges; write latency is unchanged at 2.
- Not defined: the WAIT state does not exist; read latency is 2.

## Test plan
- Reset then read addr 5: `data`=0x0000; `out_data_mem` pulses once at N+1.
- Write 0xBEEF to addr 3, then read addr 3:
  - ack at N+1 for the write;
  - read returns 0xBEEF;
  - `data` unchanged during the write.
- `write_data`=1 (addr 7, 0x1234) and `in_data_mem`=1 (addr 7) raised in the same cycle: write acks first; read acks 3 cycles later with 0x1234.
- Request held high through the ack for two cycles: second transaction starts from IDLE after DONE; two acks separated by ≥1 low cycle.
- DEPTH=12, write 0xAAAA to addr 14, then read addr 14: both ack; read returns 0x0000; addrs 0–11 unchanged.
- `rst_n` pulled low in RD: `out_data_mem`=0 and `data`=0 immediately; no ack follows; prior writes read back 0.
- With `DATA_MEM_WAIT_EN` defined: read ack at N+2; write ack still at N+1.

Source files
------------

// File: rtl/data_mem_resp.sv
// data_mem_resp: DEPTH x DW register data store answering one CPU read/write request at a time.
// Latency: read ack 2 edges after sampling (3 with DATA_MEM_WAIT_EN), write ack 2 edges; 1-cycle turnaround.
// Backpressure: requests are levels held until ack; ignored outside IDLE. Optional macro: DATA_MEM_WAIT_EN.
module data_mem_resp #(
    parameter int DW    = 16,
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_data_mem,
    input  logic [AW-1:0] adr_data,
    input  logic          write_data,
    input  logic [AW-1:0] adr_data_write,
    input  logic [DW-1:0] data_write,
    output logic [DW-1:0] data,
    output logic          out_data_mem
);

`ifdef DATA_MEM_WAIT_EN
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;
`endif

    localparam logic [AW:0] LP_DEPTH = DEPTH[AW:0];

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdat;
    logic [DW-1:0] r_mem [DEPTH];

    logic          w_lat_wr;
    logic          w_lat_rd;
    logic          w_rd_done;
    logic          w_wr_do;
    logic          w_in_range;
    logic [DW-1:0] w_rd_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lat_wr    = 1'b0;
        w_lat_rd    = 1'b0;
        w_rd_done   = 1'b0;
        w_wr_do     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Write wins a tie; the read stays asserted and is taken on the next IDLE.
                if (write_data) begin
                    w_lat_wr    = 1'b1;
                    w_state_nxt = S_WR;
                end else if (in_data_mem) begin
                    w_lat_rd    = 1'b1;
                    w_state_nxt = S_RD;
                end
            end
`ifdef DATA_MEM_WAIT_EN
            S_RD: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_rd_done   = 1'b1;
                w_state_nxt = S_DONE;
            end
`else
            S_RD: begin
                w_rd_done   = 1'b1;
                w_state_nxt = S_DONE;
            end
`endif
            S_WR: begin
                w_wr_do     = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Addresses beyond DEPTH read as zero and swallow writes.
    assign w_in_range = ({1'b0, r_addr} < LP_DEPTH);
    assign w_rd_word  = w_in_range ? r_mem[r_addr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_wdat <= '0;
        end else if (w_lat_wr) begin
            r_addr <= adr_data_write;
            r_wdat <= data_write;
        end else if (w_lat_rd) begin
            r_addr <= adr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_do && w_in_range) begin
            r_mem[r_addr] <= r_wdat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data         <= '0;
            out_data_mem <= 1'b0;
        end else begin
            out_data_mem <= w_rd_done | w_wr_do;
            if (w_rd_done) begin
                data <= w_rd_word;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// Randomized self-checking bench for data_mem_resp (DEPTH=12) against an array-based memory model.
module tb_data_mem_resp;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 12;
`ifdef DATA_MEM_WAIT_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif
    localparam int WR_LAT = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_data_mem = 1'b0;
    logic [AW-1:0] adr_data = '0;
    logic          write_data = 1'b0;
    logic [AW-1:0] adr_data_write = '0;
    logic [DW-1:0] data_write = '0;
    logic [DW-1:0] data;
    logic          out_data_mem;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_mem [16];
    logic [DW-1:0] m_data;

    bit            mon_en = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_ack;

    data_mem_resp #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_data_mem    (in_data_mem),
        .adr_data       (adr_data),
        .write_data     (write_data),
        .adr_data_write (adr_data_write),
        .data_write     (data_write),
        .data           (data),
        .out_data_mem   (out_data_mem)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (out_data_mem) begin
                checks++;
                if (prev_ack === 1'b1) begin
                    errors++;
                    $display("FAIL ack_consecutive: ack high two cycles in a row at %0t", $time);
                end
            end else begin
                checks++;
                if (data !== prev_data) begin
                    errors++;
                    $display("FAIL data_hold: data=%h changed without ack, was %h", data, prev_data);
                end
            end
        end
        prev_data = data;
        prev_ack  = out_data_mem;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        return (int'(a) < DEPTH) ? m_mem[a] : '0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        m_data = '0;
    endtask

    task automatic txn(input bit is_wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
        int cnt;
        @(negedge clk);
        if (is_wr) begin
            write_data = 1'b1; adr_data_write = a; data_write = d;
        end else begin
            in_data_mem = 1'b1; adr_data = a;
        end
        @(posedge clk); #1;
        cnt = 0;
        while (out_data_mem !== 1'b1 && cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
        end
        write_data  = 1'b0;
        in_data_mem = 1'b0;
        if (is_wr) begin
            if (int'(a) < DEPTH) m_mem[a] = d;
        end else begin
            m_data = model_read(a);
        end
        checks++;
        if (cnt != (is_wr ? WR_LAT : RD_LAT)) begin
            errors++;
            $display("FAIL %s_latency: ack after %0d edges, expected %0d", tag, cnt, is_wr ? WR_LAT : RD_LAT);
        end
        checks++;
        if (data !== m_data) begin
            errors++;
            $display("FAIL %s_data: addr %0d data=%h expected %h", tag, a, data, m_data);
        end
        @(posedge clk); #1;
        checks++;
        if (out_data_mem !== 1'b0) begin
            errors++;
            $display("FAIL %s_ack_width: ack=%b after DONE, expected 0", tag, out_data_mem);
        end
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        checks++;
        if (out_data_mem !== 1'b0 || data !== '0) begin
            errors++;
            $display("FAIL reset_state: ack=%b data=%h expected 0/0000", out_data_mem, data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic test_read_after_reset();
        txn(1'b0, 4'd5, '0, "rd_reset");
    endtask

    task automatic test_write_read();
        txn(1'b0, 4'd1, '0, "wr_rd_pre");
        txn(1'b1, 4'd3, 16'hBEEF, "wr_beef");
        txn(1'b0, 4'd3, '0, "rd_beef");
        checks++;
        if (data !== 16'hBEEF) begin
            errors++;
            $display("FAIL rd_beef_const: data=%h expected beef", data);
        end
    endtask

    task automatic test_simultaneous();
        int cnt;
        @(negedge clk);
        write_data = 1'b1; adr_data_write = 4'd7; data_write = 16'h1234;
        in_data_mem = 1'b1; adr_data = 4'd7;
        @(posedge clk); #1;
        cnt = 0;
        while (out_data_mem !== 1'b1 && cnt < 10) begin
            @(posedge clk); #1; cnt++;
        end
        write_data = 1'b0;
        m_mem[7] = 16'h1234;
        checks++;
        if (cnt != WR_LAT) begin
            errors++;
            $display("FAIL simul_wr_latency: %0d edges, expected %0d", cnt, WR_LAT);
        end
        cnt = 0;
        do begin
            @(posedge clk); #1; cnt++;
        end while (out_data_mem !== 1'b1 && cnt < 12);
        in_data_mem = 1'b0;
        m_data = model_read(4'd7);
        checks++;
        if (cnt != RD_LAT + 2) begin
            errors++;
            $display("FAIL simul_rd_gap: read ack %0d edges after write ack, expected %0d", cnt, RD_LAT + 2);
        end
        checks++;
        if (data !== m_data) begin
            errors++;
            $display("FAIL simul_rd_data: data=%h expected %h", data, m_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_held_request();
        int n_ack;
        int pos [2];
        pos[0] = -1; pos[1] = -1;
        n_ack = 0;
        @(negedge clk);
        in_data_mem = 1'b1; adr_data = 4'd3;
        @(posedge clk); #1;
        for (int e = 1; e <= 20 && n_ack < 2; e++) begin
            @(posedge clk); #1;
            if (out_data_mem === 1'b1) begin
                pos[n_ack] = e;
                n_ack++;
            end
        end
        in_data_mem = 1'b0;
        m_data = model_read(4'd3);
        checks++;
        if (pos[0] != RD_LAT || pos[1] != 2 * RD_LAT + 2) begin
            errors++;
            $display("FAIL held_ack_pos: acks at %0d,%0d expected %0d,%0d", pos[0], pos[1], RD_LAT, 2 * RD_LAT + 2);
        end
        checks++;
        if (data !== m_data) begin
            errors++;
            $display("FAIL held_data: data=%h expected %h", data, m_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            bit w;
            w = $urandom_range(0, 1) == 1;
            a = AW'($urandom_range(0, 15));
            d = DW'($urandom);
            txn(w, a, d, w ? "rand_wr" : "rand_rd");
        end
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < DEPTH; i++) begin
            logic [DW-1:0] d;
            d = DW'($urandom) | 16'h0001;
            txn(1'b1, AW'(i), d, "fill");
        end
        txn(1'b1, 4'd14, 16'hAAAA, "oor_wr");
        txn(1'b0, 4'd14, '0, "oor_rd");
        checks++;
        if (data !== 16'h0000) begin
            errors++;
            $display("FAIL oor_rd_zero: data=%h expected 0000", data);
        end
        for (int i = 0; i < DEPTH; i++) begin
            txn(1'b0, AW'(i), '0, "oor_scan");
        end
    endtask

    task automatic test_reset_mid_read();
        txn(1'b1, 4'd2, 16'h5A5A, "mid_wr");
        txn(1'b0, 4'd2, '0, "mid_rd");
        mon_en = 1'b0;
        @(negedge clk);
        in_data_mem = 1'b1; adr_data = 4'd2;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_data_mem !== 1'b0 || data !== '0) begin
            errors++;
            $display("FAIL mid_reset_now: ack=%b data=%h expected 0/0000", out_data_mem, data);
        end
        @(posedge clk); #1;
        in_data_mem = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int e = 0; e < 4; e++) begin
            @(posedge clk); #1;
            checks++;
            if (out_data_mem !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_no_ack: ack=%b at edge %0d after release, expected 0", out_data_mem, e);
            end
        end
        mon_en = 1'b1;
        txn(1'b0, 4'd2, '0, "post_rst_rd2");
        txn(1'b0, 4'd3, '0, "post_rst_rd3");
    endtask

    initial begin
        test_reset();
        test_read_after_reset();
        test_write_read();
        test_simultaneous();
        test_held_request();
        test_random();
        test_out_of_range();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
